uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART_TX instance between NUM_REQ byte producers.
- Each producer presents a byte plus its own parity configuration on a valid/ack handshake.
- Arbiter latches the winning request, drives UART_TX P_DATA/DATA_VALID/PAR_EN/PAR_TYP, and tracks UART_TX BUSY until the frame is complete before granting again.
- Sits between system-level producers (register file readback, ALU result path) and UART_TX.

Parameters:
WIDTH, 8, data byte width (matches UART_TX WIDTH)
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, grant index width, ≥ clog2(NUM_REQ)
BUSY_TIMEOUT, 4, max cycles waiting for TX_BUSY to rise after issue

Ports:
CLK  input  1  system clock (UART TX clock domain)
RST  input  1  synchronous reset, active-high
REQ_VALID  input  NUM_REQ  per-requester request, level, held until REQ_ACK
REQ_DATA  input  NUM_REQ*WIDTH  flattened bytes, requester i at [i*WIDTH +: WIDTH]
REQ_PAR_EN  input  NUM_REQ  per-requester parity enable
REQ_PAR_TYP  input  NUM_REQ  per-requester parity type (0 even, 1 odd)
REQ_ACK  output  NUM_REQ  one-cycle pulse, one-hot, request accepted
TX_P_DATA  output  WIDTH  to UART_TX P_DATA
TX_DATA_VALID  output  1  to UART_TX DATA_VALID
TX_PAR_EN  output  1  to UART_TX PAR_EN
TX_PAR_TYP  output  1  to UART_TX PAR_TYP
TX_BUSY  input  1  from UART_TX BUSY
GRANT_ID  output  ID_W  index of requester currently owning UART_TX
ARB_BUSY  output  1  high from grant until frame complete
TIMEOUT_ERR  output  1  one-cycle pulse, UART_TX never asserted BUSY

Behaviour:
- Reset (RST=1 at posedge) forces all outputs to 0, state IDLE, rr pointer 0. A mid-frame reset also drops TX_DATA_VALID immediately and discards any latched request.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any REQ_VALID=1 and TX_BUSY=0, select the first set bit searching from rr pointer upward with wrap-around.
  - Latch that requester's REQ_DATA, PAR_EN and PAR_TYP into the TX_* registers and set GRANT_ID.
  - Pulse REQ_ACK[i] for exactly this cycle, set ARB_BUSY=1, set rr pointer = (i+1) mod NUM_REQ, go to ISSUE.
  - If TX_BUSY=1 in IDLE, grant nothing.
- ISSUE: TX_DATA_VALID=1 for exactly one cycle; go to WAIT_BUSY with timeout counter cleared.
- WAIT_BUSY:
  - TX_BUSY=1 → go to WAIT_DONE.
  - Otherwise increment the counter; when it reaches BUSY_TIMEOUT, pulse TIMEOUT_ERR, clear ARB_BUSY, go to IDLE. The failed byte is dropped and its REQ_ACK is not repeated.
- WAIT_DONE: hold TX_P_DATA, TX_PAR_EN and TX_PAR_TYP stable; on TX_BUSY=0 clear ARB_BUSY and go to IDLE.
- TX_P_DATA, TX_PAR_EN, TX_PAR_TYP change only in the IDLE grant cycle; they are stable from ISSUE until the next grant.
- Latency:
  - REQ_VALID to REQ_ACK: 1 cycle if idle.
  - REQ_ACK to TX_DATA_VALID: 1 cycle.
  - Minimum gap between frames is 2 cycles after BUSY falls (IDLE grant + ISSUE).
- Requester rules:
  - REQ_VALID deasserting before ACK is legal; that request is withdrawn.
  - A requester's REQ_VALID still high in the cycle after its ACK is a new request.
- Fairness: with all NUM_REQ requesting continuously, grants cycle 0,1,2,3,0,… and no requester waits more than NUM_REQ-1 frames.
- REQ_VALID changes during ISSUE, WAIT_BUSY or WAIT_DONE have no effect until IDLE.
- TX_DATA_VALID is never asserted while TX_BUSY=1, so UART_TX never sees DATA_VALID mid-frame from this block.

Test Plan:
- Single request: REQ_VALID=0001, REQ_DATA[0]=0xCC, PAR_EN=1, PAR_TYP=0 → REQ_ACK=0001 next cycle; TX_DATA_VALID one cycle later with TX_P_DATA=0xCC; serial output 0_00110011_0_1 (start, LSB-first data, even parity, stop); ARB_BUSY clears when BUSY falls.
- Round-robin: REQ_VALID=1111 held, bytes 0x11/0x22/0x33/0x44 → frames transmitted in order 0x11,0x22,0x33,0x44,0x11; GRANT_ID sequence 0,1,2,3,0.
- Per-requester parity: req1 0xCC odd parity, req2 0xE7 no parity → 11-bit frame with parity bit 1, then 10-bit frame with no parity bit; TX_PAR_EN/TX_PAR_TYP switch only at the grant cycle.
- Late request during frame: req0 granted, req3 raises REQ_VALID mid-frame → no REQ_ACK and no TX_DATA_VALID until TX_BUSY=0; req3 granted 1 cycle after return to IDLE.
- Timeout: UART_TX BUSY tied 0, req2 0xA5 → TIMEOUT_ERR pulses exactly BUSY_TIMEOUT=4 cycles after WAIT_BUSY entry; ARB_BUSY=0; next request is granted normally.
- Reset mid-frame: assert RST during WAIT_DONE with req1 also pending → all outputs 0 next cycle; after release req1 is not granted before req0 when both request (rr pointer back to 0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
//
// Each producer offers a byte plus its own parity setting on a level valid / one-cycle ack
// handshake. The winner is latched into the TX_* registers and issued to the transmitter with
// a single DATA_VALID pulse. The arbiter then follows BUSY until the frame ends before it
// grants again.
//
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   REQ_VALID       per-requester request level, held until REQ_ACK
//   REQ_DATA        flattened request bytes, requester i at [i*WIDTH +: WIDTH]
//   REQ_PAR_EN      per-requester parity enable
//   REQ_PAR_TYP     per-requester parity type (0 even, 1 odd)
//   REQ_ACK         one-hot, one-cycle acceptance pulse
//   TX_P_DATA       byte to the transmitter
//   TX_DATA_VALID   one-cycle start strobe to the transmitter
//   TX_PAR_EN       parity enable to the transmitter
//   TX_PAR_TYP      parity type to the transmitter
//   TX_BUSY         frame-in-progress flag from the transmitter
//   GRANT_ID        index of the requester owning the transmitter
//   ARB_BUSY        high from grant until the frame completes
//   TIMEOUT_ERR     one-cycle pulse when the transmitter never raised BUSY
module uart_tx_arbiter #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned ID_W         = 2,
   parameter int unsigned BUSY_TIMEOUT = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       REQ_VALID,
   input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]       REQ_PAR_EN,
   input  logic [NUM_REQ-1:0]       REQ_PAR_TYP,
   output logic [NUM_REQ-1:0]       REQ_ACK,
   output logic [WIDTH-1:0]         TX_P_DATA,
   output logic                     TX_DATA_VALID,
   output logic                     TX_PAR_EN,
   output logic                     TX_PAR_TYP,
   input  logic                     TX_BUSY,
   output logic [ID_W-1:0]          GRANT_ID,
   output logic                     ARB_BUSY,
   output logic                     TIMEOUT_ERR
);

   localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitBusy,
      StWaitDone
   } state_e;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    rr_q, rr_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic               par_en_q, par_en_d;
   logic               par_typ_q, par_typ_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               valid_q, valid_d;
   logic               arb_busy_q, arb_busy_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [WIDTH-1:0]   req_bytes [NUM_REQ];
   logic               found;
   logic [ID_W-1:0]    sel;
   logic [ID_W-1:0]    cand;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = REQ_DATA[g*WIDTH +: WIDTH];
   end

   // First requesting index at or above the rr pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
         if (!found && REQ_VALID[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // REQ_ACK and the TX_* fields are registered at the grant edge, so the ack is visible while
   // in StIssue and the DATA_VALID strobe follows one cycle later, on leaving StIssue.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      ack_d      = '0;
      valid_d    = 1'b0;
      arb_busy_d = arb_busy_q;
      timeout_d  = 1'b0;
      cnt_d      = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (found && !TX_BUSY) begin
               grant_d    = sel;
               data_d     = req_bytes[sel];
               par_en_d   = REQ_PAR_EN[sel];
               par_typ_d  = REQ_PAR_TYP[sel];
               ack_d      = NUM_REQ'(1) << sel;
               arb_busy_d = 1'b1;
               rr_d       = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (TX_BUSY) begin
               state_d = StWaitDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
               // Byte is dropped on timeout; no re-ack, the requester must ask again.
               if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                  timeout_d  = 1'b1;
                  arb_busy_d = 1'b0;
                  state_d    = StIdle;
               end
            end
         end
         StWaitDone: begin
            if (!TX_BUSY) begin
               arb_busy_d = 1'b0;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StIdle;
         rr_q       <= '0;
         grant_q    <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         ack_q      <= '0;
         valid_q    <= 1'b0;
         arb_busy_q <= 1'b0;
         timeout_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         ack_q      <= ack_d;
         valid_q    <= valid_d;
         arb_busy_q <= arb_busy_d;
         timeout_q  <= timeout_d;
         cnt_q      <= cnt_d;
      end
   end

   assign REQ_ACK       = ack_q;
   assign TX_P_DATA     = data_q;
   assign TX_DATA_VALID = valid_q;
   assign TX_PAR_EN     = par_en_q;
   assign TX_PAR_TYP    = par_typ_q;
   assign GRANT_ID      = grant_q;
   assign ARB_BUSY      = arb_busy_q;
   assign TIMEOUT_ERR   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios against a small behavioural UART transmitter.
// Expected acks and frames (hand-computed serial bit strings) go into scoreboard queues; two
// monitor processes pop and compare whenever the DUT acks or strobes TX_DATA_VALID.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_par_en;
   logic [3:0]  req_par_typ;
   logic [3:0]  req_ack;
   logic [7:0]  tx_p_data;
   logic        tx_data_valid;
   logic        tx_par_en;
   logic        tx_par_typ;
   logic        tx_busy;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;

   uart_tx_arbiter #(
      .WIDTH       (8),
      .NUM_REQ     (4),
      .ID_W        (2),
      .BUSY_TIMEOUT(4)
   ) dut (
      .CLK          (clk),
      .RST          (rst),
      .REQ_VALID    (req_valid),
      .REQ_DATA     (req_data),
      .REQ_PAR_EN   (req_par_en),
      .REQ_PAR_TYP  (req_par_typ),
      .REQ_ACK      (req_ack),
      .TX_P_DATA    (tx_p_data),
      .TX_DATA_VALID(tx_data_valid),
      .TX_PAR_EN    (tx_par_en),
      .TX_PAR_TYP   (tx_par_typ),
      .TX_BUSY      (tx_busy),
      .GRANT_ID     (grant_id),
      .ARB_BUSY     (arb_busy),
      .TIMEOUT_ERR  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural UART transmitter: one bit per cycle, start, LSB-first data, optional parity, stop.
   logic        busy_stuck_low = 1'b0;
   logic        m_busy;
   logic [10:0] m_sh;
   int          m_rem;
   logic        ser_line;

   function automatic logic [10:0] build_frame(input logic [7:0] d, input logic en,
                                               input logic typ);
      logic [10:0] b;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[1+i] = d[i];
      if (en) b[9] = typ ? ~^d : ^d;
      return b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_rem  <= 0;
         m_sh   <= '0;
      end else if (m_busy) begin
         m_sh  <= m_sh >> 1;
         m_rem <= m_rem - 1;
         if (m_rem == 1) m_busy <= 1'b0;
      end else if (tx_data_valid && !busy_stuck_low) begin
         m_sh   <= build_frame(tx_p_data, tx_par_en, tx_par_typ);
         m_rem  <= tx_par_en ? 11 : 10;
         m_busy <= 1'b1;
      end
   end

   assign tx_busy  = m_busy;
   assign ser_line = m_busy ? m_sh[0] : 1'b1;

   typedef struct {
      logic [1:0]  id;
      logic [7:0]  data;
      logic        en;
      logic        typ;
      logic        frame;
      logic [10:0] bits;
      int          len;
   } tx_exp_t;

   tx_exp_t tx_q[$];
   int      ack_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_tx(input logic [1:0] id, input logic [7:0] d, input logic en,
                          input logic typ, input logic fr, input logic [10:0] bits,
                          input int len);
      tx_exp_t e;
      e.id = id; e.data = d; e.en = en; e.typ = typ; e.frame = fr; e.bits = bits; e.len = len;
      tx_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (req_ack == 4'b0 && n < 60);
      check("ack_seen", 32'(|req_ack), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((arb_busy || tx_busy) && n < 60) begin
         tick();
         n++;
      end
      check("idle_reached", 32'(arb_busy | tx_busy), 0);
      tick();
   endtask

   // Ack monitor.
   initial begin : ack_monitor
      int e;
      forever begin
         @(negedge clk);
         if (req_ack != 4'b0) begin
            if (ack_q.size() == 0) begin
               check("ack_unexpected", 32'(req_ack), 0);
            end else begin
               e = ack_q.pop_front();
               check("ack_onehot", 32'(req_ack), 32'(1) << e);
            end
         end
      end
   end

   // Issue and serial-frame monitor.
   initial begin : tx_monitor
      tx_exp_t     e;
      logic [10:0] cap;
      int          n;
      int          w;
      forever begin
         @(negedge clk);
         if (tx_data_valid) begin
            check("valid_while_busy", 32'(tx_busy), 0);
            if (tx_q.size() == 0) begin
               check("valid_unexpected", 32'(tx_data_valid), 0);
            end else begin
               e = tx_q.pop_front();
               check("tx_grant_id", 32'(grant_id), 32'(e.id));
               check("tx_p_data", 32'(tx_p_data), 32'(e.data));
               check("tx_par_en", 32'(tx_par_en), 32'(e.en));
               check("tx_par_typ", 32'(tx_par_typ), 32'(e.typ));
               if (e.frame) begin
                  w = 0;
                  while (!tx_busy && w < 10) begin
                     @(negedge clk);
                     w++;
                  end
                  cap = '0;
                  n   = 0;
                  while (tx_busy && n < 20) begin
                     cap = {cap[9:0], ser_line};
                     n++;
                     @(negedge clk);
                  end
                  check("frame_len", 32'(n), 32'(e.len));
                  check("frame_bits", 32'(cap), 32'(e.bits));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      logic early;
      logic par_bad;

      rst         = 1'b1;
      req_valid   = '0;
      req_data    = '0;
      req_par_en  = '0;
      req_par_typ = '0;
      tick();
      tick();
      check("reset_outputs", 32'({req_ack, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
                                  grant_id, arb_busy, timeout_err}), 0);
      rst = 1'b0;
      tick();

      // Round robin, all four requesting continuously, no parity.
      req_data = 32'h4433_2211;
      for (int k = 0; k < 5; k++) ack_q.push_back(k % 4);
      push_tx(2'd0, 8'h11, 1'b0, 1'b0, 1'b1, 11'(10'b0_10001000_1), 10);
      push_tx(2'd1, 8'h22, 1'b0, 1'b0, 1'b1, 11'(10'b0_01000100_1), 10);
      push_tx(2'd2, 8'h33, 1'b0, 1'b0, 1'b1, 11'(10'b0_11001100_1), 10);
      push_tx(2'd3, 8'h44, 1'b0, 1'b0, 1'b1, 11'(10'b0_00100010_1), 10);
      push_tx(2'd0, 8'h11, 1'b0, 1'b0, 1'b1, 11'(10'b0_10001000_1), 10);
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ack(n);
         check("rr_grant_id", 32'(grant_id), 32'(k % 4));
         if (k == 4) req_valid = '0;
      end
      wait_idle();

      // Single request, even parity; rr pointer is 1 so the search wraps to 0.
      req_data[7:0]  = 8'hCC;
      req_par_en[0]  = 1'b1;
      req_par_typ[0] = 1'b0;
      ack_q.push_back(0);
      push_tx(2'd0, 8'hCC, 1'b1, 1'b0, 1'b1, 11'b0_00110011_0_1, 11);
      req_valid = 4'b0001;
      wait_ack(n);
      req_valid = '0;
      check("ack_latency", 32'(n), 1);
      check("arb_busy_on_grant", 32'(arb_busy), 1);
      tick();
      check("valid_after_ack", 32'(tx_data_valid), 1);
      tick();
      check("valid_one_cycle", 32'(tx_data_valid), 0);
      wait_idle();

      // Per-requester parity: req1 odd, then req2 without parity.
      req_par_en      = 4'b0010;
      req_par_typ     = 4'b0010;
      req_data[15:8]  = 8'hCC;
      req_data[23:16] = 8'hE7;
      ack_q.push_back(1);
      ack_q.push_back(2);
      push_tx(2'd1, 8'hCC, 1'b1, 1'b1, 1'b1, 11'b0_00110011_1_1, 11);
      push_tx(2'd2, 8'hE7, 1'b0, 1'b0, 1'b1, 11'(10'b0_11100111_1), 10);
      req_valid = 4'b0110;
      wait_ack(n);
      req_valid[1] = 1'b0;
      check("par_grant_id_1", 32'(grant_id), 1);
      par_bad = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
         if (req_ack == 4'b0 && (tx_par_en !== 1'b1 || tx_par_typ !== 1'b1)) par_bad = 1'b1;
      end while (req_ack == 4'b0 && n < 60);
      req_valid[2] = 1'b0;
      check("par_stable_until_grant", 32'(par_bad), 0);
      check("par_grant_id_2", 32'(grant_id), 2);
      check("par_en_switched", 32'(tx_par_en), 0);
      wait_idle();

      // Late request raised mid-frame.
      req_par_en     = '0;
      req_par_typ    = '0;
      req_data[7:0]  = 8'h3C;
      ack_q.push_back(0);
      ack_q.push_back(3);
      push_tx(2'd0, 8'h3C, 1'b0, 1'b0, 1'b1, 11'(10'b0_00111100_1), 10);
      push_tx(2'd3, 8'h44, 1'b0, 1'b0, 1'b1, 11'(10'b0_00100010_1), 10);
      req_valid = 4'b0001;
      wait_ack(n);
      req_valid = '0;
      n = 0;
      while (!tx_busy && n < 20) begin
         tick();
         n++;
      end
      req_valid[3] = 1'b1;
      early = 1'b0;
      n = 0;
      while (tx_busy && n < 60) begin
         tick();
         n++;
         if (req_ack != 4'b0) early = 1'b1;
      end
      check("no_ack_mid_frame", 32'(early), 0);
      wait_ack(n);
      req_valid = '0;
      check("late_grant_latency", 32'(n), 2);
      check("late_grant_id", 32'(grant_id), 3);
      wait_idle();

      // Timeout: transmitter never raises BUSY.
      busy_stuck_low  = 1'b1;
      req_data[23:16] = 8'hA5;
      ack_q.push_back(2);
      push_tx(2'd2, 8'hA5, 1'b0, 1'b0, 1'b0, 11'b0, 0);
      req_valid = 4'b0100;
      wait_ack(n);
      req_valid = '0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!timeout_err && n < 20);
      // Ack cycle, entry into WAIT_BUSY, then BUSY_TIMEOUT more cycles.
      check("timeout_latency", 32'(n), 5);
      check("timeout_arb_busy", 32'(arb_busy), 0);
      tick();
      check("timeout_pulse_width", 32'(timeout_err), 0);
      busy_stuck_low = 1'b0;
      req_data[7:0]  = 8'h0F;
      ack_q.push_back(0);
      push_tx(2'd0, 8'h0F, 1'b0, 1'b0, 1'b1, 11'(10'b0_11110000_1), 10);
      req_valid = 4'b0001;
      wait_ack(n);
      req_valid = '0;
      check("post_timeout_ack_latency", 32'(n), 1);
      wait_idle();

      // Reset mid-frame with req1 pending; rr pointer is 1 before the reset.
      ack_q.push_back(0);
      push_tx(2'd0, 8'h0F, 1'b0, 1'b0, 1'b0, 11'b0, 0);
      req_valid = 4'b0001;
      wait_ack(n);
      req_valid       = 4'b0010;
      req_data[15:8]  = 8'h96;
      req_par_en[1]   = 1'b1;
      n = 0;
      while (!tx_busy && n < 20) begin
         tick();
         n++;
      end
      tick();
      tick();
      check("busy_before_reset", 32'(arb_busy), 1);
      rst = 1'b1;
      tick();
      check("reset_mid_frame", 32'({req_ack, tx_p_data, tx_data_valid, tx_par_en, tx_par_typ,
                                    grant_id, arb_busy, timeout_err}), 0);
      rst           = 1'b0;
      req_data[7:0] = 8'h81;
      ack_q.push_back(0);
      ack_q.push_back(1);
      push_tx(2'd0, 8'h81, 1'b0, 1'b0, 1'b1, 11'(10'b0_10000001_1), 10);
      push_tx(2'd1, 8'h96, 1'b1, 1'b0, 1'b1, 11'b0_01101001_0_1, 11);
      req_valid = 4'b0011;
      wait_ack(n);
      req_valid[0] = 1'b0;
      check("post_reset_first_grant", 32'(grant_id), 0);
      wait_ack(n);
      req_valid = '0;
      check("post_reset_second_grant", 32'(grant_id), 1);
      wait_idle();
      tick();

      check("ack_queue_drained", 32'(ack_q.size()), 0);
      check("tx_queue_drained", 32'(tx_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
